// File: rtl/shift16_iter.sv
// Purpose : iterative SHL/SHR unit, one bit position per clock, feeding the ALU result/flag select stage.
// Latency : start accepted at edge E0 -> done high in the cycle after edge E0+count (count=0: cycle after E0).
// Backpress: none queued; start is only sampled while busy=0, requests during SHIFT are dropped.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start, dir, sar     request, direction (0=left, 1=right), arithmetic-right request
//   a, count, cf_in     operand, number of single-bit shifts, carry passed through when count=0
//   y, cf               result and last bit shifted out; held until the next accepted start
//   busy, done          high in SHIFT; one-cycle completion pulse
//
// Build option: define SHIFT16_SAR_EN to honour sar (sign fill on right shifts).
// Without it, sar is still a port but right shifts always zero-fill.

module shift16_iter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic             sar,
    input  logic [WIDTH-1:0] a,
    input  logic [CNT_W-1:0] count,
    input  logic             cf_in,
    output logic [WIDTH-1:0] y,
    output logic             cf,
    output logic             busy,
    output logic             done
);

`ifdef SHIFT16_SAR_EN
    localparam logic SAR_EN = 1'b1;
`else
    localparam logic SAR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic             mode_dir;
    logic             mode_sar;

    logic             fill;
    logic [WIDTH-1:0] y_shifted;
    logic             cf_shifted;

    // One single-bit step of the latched operation. The sign fill is gated by
    // the build-time enable so the default build reduces to a zero fill.
    always_comb begin
        fill       = SAR_EN & mode_sar & y[WIDTH-1];
        y_shifted  = {y[WIDTH-2:0], 1'b0};
        cf_shifted = y[WIDTH-1];
        if (mode_dir) begin
            y_shifted  = {fill, y[WIDTH-1:1]};
            cf_shifted = y[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            y         <= '0;
            cf        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
            mode_dir  <= 1'b0;
            mode_sar  <= 1'b0;
        end else begin
            case (state)
                // DONE accepts a new start on its single cycle, so
                // back-to-back operations run without an idle bubble.
                IDLE, DONE: begin
                    if (start) begin
                        y         <= a;
                        remaining <= count;
                        mode_dir  <= dir;
                        mode_sar  <= sar;
                        if (count == '0) begin
                            cf    <= cf_in;
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                SHIFT: begin
                    y         <= y_shifted;
                    cf        <= cf_shifted;
                    remaining <= remaining - CNT_W'(1);
                    // Last step happens on the edge where remaining goes 1 -> 0.
                    if (remaining == CNT_W'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/shift16_iter.md
Name: shift16_iter

Overview:
- Iterative 16-bit shift unit. Performs SHL/SHR one bit per clock for a 5-bit count.
- Sits directly upstream of the ALU result/flag select stage. Its y/cf outputs drive that stage's y_shl/cf_shl (dir=0) and y_shr/cf_shr (dir=1) inputs.
- Sequencer issues start, waits for done, then selects op 6/7 in the ALU select stage.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥2.
- CNT_W, 5, shift-count width; counts 0..2^CNT_W-1 accepted unmasked.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- dir  input  1  0=shift left, 1=shift right
- sar  input  1  arithmetic-right request (see Optional Feature)
- a  input  WIDTH  operand
- count  input  CNT_W  number of single-bit shifts
- cf_in  input  1  current carry flag, passed through when count=0
- y  output  WIDTH  shifted result; valid while done=1, held until next accepted start
- cf  output  1  last bit shifted out (or cf_in for count=0)
- busy  output  1  high in SHIFT state
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0): state=IDLE; y=0, cf=0, busy=0, done=0, internal count=0. Applies immediately, including mid-operation. The in-flight shift is discarded and no done is produced.
- States: IDLE, SHIFT, DONE. busy=1 only in SHIFT; done=1 only in DONE.
- Accept: start=1 at an edge while state is IDLE or DONE.
  - Latch a into y, count into remaining-count register, dir/sar into mode registers.
  - count=0: load cf=cf_in, go to DONE.
  - count≠0: cf unchanged, go to SHIFT.
- SHIFT, each edge:
  - Left: cf←y[WIDTH-1], y←{y[WIDTH-2:0],0}.
  - Right: cf←y[0], y←{fill,y[WIDTH-1:1]}; fill=0 unless SAR active.
  - Decrement remaining; when it reaches 0 on this edge, go to DONE.
- DONE: done=1 for exactly one cycle. Next state is IDLE, or re-load if start=1 on that edge (back-to-back allowed, no bubble).
- Latency: start accepted at edge E0 → done high in the cycle following edge E0+N (N=count). For N=0, done is high in the cycle right after E0.
- start while busy=1 is ignored entirely: no latch, no queue. Inputs a/count/dir/cf_in may change freely during SHIFT without effect.
- Count > WIDTH: shifting continues.
  - Logical shift: y=0 after WIDTH shifts; cf=0 from shift WIDTH+1 on.
  - With SAR, y saturates to all-sign and cf=sign.
- y/cf hold their last values in IDLE. Neither is cleared by done falling.

Optional Feature:
- Macro SHIFT16_SAR_EN.
- Defined: when dir=1 and latched sar=1, fill bit = y[WIDTH-1] (arithmetic shift right). cf behaves as in SHR.
- Undefined: sar port present but ignored; right shifts always zero-fill. The port list is identical in both builds.

Test Plan:
- SHL a=0x8001, count=1, cf_in=0 → done one cycle after the shift edge; y=0x0002, cf=1; busy high exactly 1 cycle.
- SHR a=0x0003, count=2 → y=0x0000, cf=1; busy 2 cycles; done pulse 1 cycle; y/cf held 5 idle cycles afterward.
- count=0, a=0x1234, cf_in=1 → busy never asserts; done next cycle; y=0x1234, cf=1.
- SHL a=0xFFFF, count=20 → busy 20 cycles; y=0x0000, cf=0. Second start (a=0x0001, count=1) pulsed mid-op is ignored. Back-to-back start during done → new result 0x0002 with no idle gap.
- rst_n low during cycle 3 of a count=10 shift → all outputs 0 immediately; no done after release. Fresh start works normally.
- dir=1, sar=1, a=0x8000, count=4 → with SHIFT16_SAR_EN: y=0xF800, cf=0; without it: y=0x0800, cf=0.
